// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
//   Display back-end: converts a 14-bit binary value to five BCD digits with a
//   sequential double-dabble engine and time-multiplexes eight active-low
//   seven-segment digits.
// Ports
//   clock_i  : system clock, all state on rising edge
//   reset_i  : asynchronous active-high reset
//   value_i  : binary value to display (0..16383)
//   bcd_o    : last completed conversion {d4,d3,d2,d1,d0}
//   busy_o   : conversion in progress
//   anode_o  : digit enables, active-low, one-hot-zero
//   seg_o    : {dp,g,f,e,d,c,b,a}, active-low, dp always off
module seg7_scan_driver #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter bit          LZ_BLANK    = 1'b1
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic [13:0] value_i,
  output logic [19:0] bcd_o,
  output logic        busy_o,
  output logic [7:0]  anode_o,
  output logic [7:0]  seg_o
);

  localparam int unsigned VAL_W   = 14;
  localparam int unsigned NDIG    = 5;
  localparam int unsigned BCD_W   = 4 * NDIG;
  localparam int unsigned SHR_W   = VAL_W + BCD_W;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned DIV_W   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IDX_W   = 3;
  localparam int unsigned SEG_W   = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [SHR_W-1:0]   shift_q, shift_d;
  logic [SHR_W-1:0]   adjusted;
  logic [VAL_W-1:0]   last_val_q, last_val_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               busy_q, busy_d;
  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic [IDX_W-1:0]   digit_idx_q, digit_idx_d;
  logic [SEG_W-1:0]   anode_q, anode_d;
  logic [SEG_W-1:0]   seg_q, seg_d;

  // Digit to active-low segment pattern; non-decimal nibbles are dark.
  function automatic logic [SEG_W-1:0] seg_lut(input logic [3:0] d);
    logic [SEG_W-1:0] s;
    case (d)
      4'd0:    s = 8'hC0;
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hF8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      default: s = 8'hFF;
    endcase
    return s;
  endfunction

  // Double-dabble correction: each BCD nibble >= 5 gets +3 before the shift.
  always_comb begin
    adjusted = shift_q;
    for (int i = 0; i < int'(NDIG); i++) begin
      if (shift_q[VAL_W + 4*i +: 4] >= 4'd5) begin
        adjusted[VAL_W + 4*i +: 4] = shift_q[VAL_W + 4*i +: 4] + 4'd3;
      end
    end
  end

  // Converter next-state logic.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    last_val_d = last_val_q;
    bit_cnt_d  = bit_cnt_q;
    bcd_d      = bcd_q;
    case (state_q)
      ST_IDLE: begin
        if (value_i != last_val_q) begin
          shift_d    = {BCD_W'(0), value_i};
          last_val_d = value_i;
          bit_cnt_d  = '0;
          state_d    = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        shift_d   = adjusted << 1;
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
        if (bit_cnt_q == CNT_W'(VAL_W - 1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        bcd_d   = shift_q[SHR_W-1:VAL_W];
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // Scan divider: advance to the next digit on each divider wrap.
  always_comb begin
    div_cnt_d   = div_cnt_q + DIV_W'(1);
    digit_idx_d = digit_idx_q;
    if (div_cnt_q == DIV_W'(REFRESH_DIV - 1)) begin
      div_cnt_d   = '0;
      digit_idx_d = digit_idx_q + IDX_W'(1);
    end
  end

  // Output decode from the committed BCD value; higher digits blank when
  // they and everything above them are zero.
  always_comb begin
    anode_d = ~(SEG_W'(1) << digit_idx_q);
    seg_d   = 8'hFF;
    case (digit_idx_q)
      3'd0: seg_d = seg_lut(bcd_q[3:0]);
      3'd1: seg_d = (LZ_BLANK && bcd_q[19:4]  == '0) ? 8'hFF : seg_lut(bcd_q[7:4]);
      3'd2: seg_d = (LZ_BLANK && bcd_q[19:8]  == '0) ? 8'hFF : seg_lut(bcd_q[11:8]);
      3'd3: seg_d = (LZ_BLANK && bcd_q[19:12] == '0) ? 8'hFF : seg_lut(bcd_q[15:12]);
      3'd4: seg_d = (LZ_BLANK && bcd_q[19:16] == '0) ? 8'hFF : seg_lut(bcd_q[19:16]);
      default: seg_d = 8'hFF;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      last_val_q  <= '0;
      bit_cnt_q   <= '0;
      bcd_q       <= '0;
      busy_q      <= 1'b0;
      div_cnt_q   <= '0;
      digit_idx_q <= '0;
      anode_q     <= 8'hFF;
      seg_q       <= 8'hFF;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      last_val_q  <= last_val_d;
      bit_cnt_q   <= bit_cnt_d;
      bcd_q       <= bcd_d;
      busy_q      <= busy_d;
      div_cnt_q   <= div_cnt_d;
      digit_idx_q <= digit_idx_d;
      anode_q     <= anode_d;
      seg_q       <= seg_d;
    end
  end

  assign bcd_o   = bcd_q;
  assign busy_o  = busy_q;
  assign anode_o = anode_q;
  assign seg_o   = seg_q;

endmodule
